// File: rtl/glitc_ritc_ctrl_tx_pkg.sv
// ============================================================================
// glitc_ritc_ctrl_tx_pkg : FSM encodings and frame sizing for the RITC control link
// Rev 1.0
// ============================================================================
`default_nettype none

package glitc_ritc_ctrl_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_ADDR_BITS = 7;
    localparam int DEF_DATA_BITS = 12;
    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_LOAD_HOLD = 2;

    function automatic int frame_bits(input int addr_bits, input int data_bits);
        return addr_bits + data_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/glitc_ritc_sclk_gen.sv
// ============================================================================
// glitc_ritc_sclk_gen : SCLK phase counter with rise/fall clock-enable pulses
// Rev 1.0
// ============================================================================
`default_nettype none

module glitc_ritc_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_ce_o,
    output logic fall_ce_o
);

    localparam int PHASES = 2 * CLK_DIV;
    localparam int CW     = (PHASES > 2) ? $clog2(PHASES) : 1;

    localparam logic [CW-1:0] C_LAST      = CW'(PHASES - 1);
    localparam logic [CW-1:0] C_HALF      = CW'(CLK_DIV);
    localparam logic [CW-1:0] C_HALF_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;

    // The ce pulses flag the edge on which the registered SCLK will change.
    always_comb begin
        rise_ce_o = en_i && (cnt_q == C_HALF_LAST);
        fall_ce_o = en_i && (cnt_q == C_LAST);
        cnt_d     = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + CW'(1);
        end
        sclk_d = (cnt_d >= C_HALF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

`default_nettype wire

// File: rtl/glitc_ritc_ctrl_tx.sv
// ============================================================================
// glitc_ritc_ctrl_tx : serialises {addr,data} to one RITC and captures DOUT readback
// Rev 1.0
// ============================================================================
`default_nettype none

module glitc_ritc_ctrl_tx
    import glitc_ritc_ctrl_tx_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int LOAD_HOLD = DEF_LOAD_HOLD
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cmd_valid_i,
    output logic                                 cmd_ready_o,
    input  logic [ADDR_BITS-1:0]                 cmd_addr_i,
    input  logic [DATA_BITS-1:0]                 cmd_data_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [ADDR_BITS+DATA_BITS-1:0]       rdata_o,
    output logic                                 RITC_SCLK,
    output logic                                 RITC_DIN,
    output logic                                 RITC_LOAD,
    input  logic                                 RITC_DOUT
);

    localparam int FB       = frame_bits(ADDR_BITS, DATA_BITS);
    localparam int LOAD_CYC = 2 * CLK_DIV * LOAD_HOLD;
    localparam int BCW      = $clog2(FB + 1);
    localparam int LCW      = (LOAD_CYC > 2) ? $clog2(LOAD_CYC) : 1;

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              din_q, din_d;
    logic              load_q, load_d;
    logic [FB-1:0]     tx_q, tx_d;
    logic [FB-1:0]     cap_q, cap_d;
    logic [FB-1:0]     rdata_q, rdata_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [LCW-1:0]    load_cnt_q, load_cnt_d;
    logic              dout_q;

    logic              sclk_w, rise_ce_w, fall_ce_w;
    logic [FB-1:0]     frame_w;

    assign frame_w = {cmd_addr_i, cmd_data_i};

    // Cleared outside SHIFT so every frame starts with a full SCLK-low phase.
    glitc_ritc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q != ST_SHIFT),
        .en_i      (state_q == ST_SHIFT),
        .sclk_o    (sclk_w),
        .rise_ce_o (rise_ce_w),
        .fall_ce_o (fall_ce_w)
    );

    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        din_d      = din_q;
        load_d     = load_q;
        tx_d       = tx_q;
        cap_d      = cap_q;
        rdata_d    = rdata_q;
        bit_cnt_d  = bit_cnt_q;
        load_cnt_d = load_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && ready_q) begin
                    state_d   = ST_SHIFT;
                    din_d     = frame_w[FB-1];
                    tx_d      = frame_w << 1;
                    cap_d     = '0;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (rise_ce_w) begin
                    cap_d = {cap_q[FB-2:0], dout_q};
                end
                // The fall after the last bit doubles as the entry into LOAD.
                if (fall_ce_w) begin
                    if (bit_cnt_q == BCW'(FB - 1)) begin
                        state_d    = ST_LOAD;
                        din_d      = 1'b0;
                        load_d     = 1'b1;
                        load_cnt_d = '0;
                    end else begin
                        din_d     = tx_q[FB-1];
                        tx_d      = tx_q << 1;
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            ST_LOAD: begin
                if (load_cnt_q == LCW'(LOAD_CYC - 1)) begin
                    state_d = ST_DONE;
                    load_d  = 1'b0;
                    done_d  = 1'b1;
                    rdata_d = cap_q;
                end else begin
                    load_cnt_d = load_cnt_q + LCW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            din_q      <= 1'b0;
            load_q     <= 1'b0;
            tx_q       <= '0;
            cap_q      <= '0;
            rdata_q    <= '0;
            bit_cnt_q  <= '0;
            load_cnt_q <= '0;
            dout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            din_q      <= din_d;
            load_q     <= load_d;
            tx_q       <= tx_d;
            cap_q      <= cap_d;
            rdata_q    <= rdata_d;
            bit_cnt_q  <= bit_cnt_d;
            load_cnt_q <= load_cnt_d;
            dout_q     <= RITC_DOUT;
        end
    end

    assign cmd_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rdata_o     = rdata_q;
    assign RITC_SCLK   = sclk_w;
    assign RITC_DIN    = din_q;
    assign RITC_LOAD   = load_q;

endmodule

`default_nettype wire

// File: tb/tb_glitc_ritc_ctrl_tx.sv
// ============================================================================
// tb_glitc_ritc_ctrl_tx : directed bench for the RITC control transmitter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_glitc_ritc_ctrl_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid_a, ready_a, busy_a, done_a, sclk_a, din_a, load_a, dout_a;
    logic [6:0]  addr_a;
    logic [11:0] data_a;
    logic [18:0] rdata_a;
    logic        valid_b, ready_b, busy_b, done_b, sclk_b, din_b, load_b, dout_b;
    logic [6:0]  addr_b;
    logic [11:0] data_b;
    logic [18:0] rdata_b;

    glitc_ritc_ctrl_tx u_dut_a (
        .clk (clk), .rst (rst),
        .cmd_valid_i (valid_a), .cmd_ready_o (ready_a),
        .cmd_addr_i (addr_a), .cmd_data_i (data_a),
        .busy_o (busy_a), .done_o (done_a), .rdata_o (rdata_a),
        .RITC_SCLK (sclk_a), .RITC_DIN (din_a), .RITC_LOAD (load_a), .RITC_DOUT (dout_a)
    );

    glitc_ritc_ctrl_tx #(.CLK_DIV(1), .LOAD_HOLD(1)) u_dut_b (
        .clk (clk), .rst (rst),
        .cmd_valid_i (valid_b), .cmd_ready_o (ready_b),
        .cmd_addr_i (addr_b), .cmd_data_i (data_b),
        .busy_o (busy_b), .done_o (done_b), .rdata_o (rdata_b),
        .RITC_SCLK (sclk_b), .RITC_DIN (din_b), .RITC_LOAD (load_b), .RITC_DOUT (dout_b)
    );

    // RITC DOUT model: presents pattern bit k (MSB first) until the k-th SCLK rise.
    int          rise_a    = 0;
    int          dout_base = 0;
    logic [18:0] dout_pat  = '0;
    always @(posedge sclk_a) rise_a <= rise_a + 1;
    always_comb begin
        int k;
        k      = rise_a - dout_base;
        dout_a = 1'b0;
        if (k >= 0 && k < 19) dout_a = dout_pat[18-k];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_accept(input bit sel, input logic [6:0] a, input logic [11:0] d, input bit hold);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if ((sel ? ready_b : ready_a) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) check("accept wait", 32'd0, 32'd1);
        if (sel) begin
            valid_b = 1'b1; addr_b = a; data_b = d;
        end else begin
            valid_a = 1'b1; addr_a = a; data_a = d;
            dout_base = rise_a;
        end
        @(posedge clk); #1;
        if (!hold) begin
            valid_a = 1'b0;
            valid_b = 1'b0;
        end
    endtask

    // Called at the sample just after the accept edge; returns at the done_o sample.
    task automatic watch_frame(input bit sel, input int div, input logic [18:0] exp_frame,
                               input logic [18:0] exp_rdata, input int exp_loads,
                               input int exp_lat, input string tag);
        logic        sc, psc, dn, pdn;
        logic [18:0] got, rd;
        int          rises, loads, lat;
        bit          stable, sclk_ok;
        got = '0; rd = '0; rises = 0; loads = 0; lat = -1;
        stable = 1'b1; sclk_ok = 1'b1; psc = 1'b0;
        pdn = sel ? din_b : din_a;
        for (int n = 0; n < 600; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            sc = sel ? sclk_b : sclk_a;
            dn = sel ? din_b : din_a;
            if (n < 2 * div * 19 && sc !== (((n / div) % 2) == 1)) sclk_ok = 1'b0;
            if (sc && !psc) begin
                got = {got[17:0], dn};
                rises++;
                if (dn !== pdn) stable = 1'b0;
            end
            if ((sel ? load_b : load_a) === 1'b1) loads++;
            if ((sel ? done_b : done_a) === 1'b1) begin
                lat = n + 1;
                rd  = sel ? rdata_b : rdata_a;
                break;
            end
            psc = sc;
            pdn = dn;
        end
        check({tag, " din bits"}, 32'(got), 32'(exp_frame));
        check({tag, " din stable at rise"}, 32'(stable), 32'd1);
        check({tag, " sclk rises"}, rises, 19);
        check({tag, " sclk waveform"}, 32'(sclk_ok), 32'd1);
        check({tag, " load cycles"}, loads, exp_loads);
        check({tag, " done latency"}, lat, exp_lat);
        check({tag, " rdata at done"}, 32'(rd), 32'(exp_rdata));
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic [11:0] data;
        logic [18:0] dpat;
        logic [18:0] frame;
        logic [18:0] rdata;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{7'h2A, 12'hABC, 19'h51234, 19'h2AABC, 19'h51234};
        vecs[1] = '{7'h7F, 12'hFFF, 19'h00000, 19'h7FFFF, 19'h00000};
        vecs[2] = '{7'h00, 12'h000, 19'h7FFFF, 19'h00000, 19'h7FFFF};
        vecs[3] = '{7'h55, 12'hA5A, 19'h2AAAA, 19'h55A5A, 19'h2AAAA};
        vecs[4] = '{7'h01, 12'h800, 19'h40001, 19'h01800, 19'h40001};

        rst = 1'b1;
        valid_a = 1'b0; addr_a = '0; data_a = '0;
        valid_b = 1'b0; addr_b = '0; data_b = '0; dout_b = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("reset outputs a", 32'({ready_a, busy_a, done_a, rdata_a, sclk_a, din_a, load_a}), 32'd0);
            check("reset outputs b", 32'({ready_b, busy_b, done_b, rdata_b, sclk_b, din_b, load_b}), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready after reset a", 32'({ready_a, busy_a}), 32'b10);
        check("ready after reset b", 32'({ready_b, busy_b}), 32'b10);

        for (int i = 0; i < 5; i++) begin
            dout_pat = vecs[i].dpat;
            do_accept(1'b0, vecs[i].addr, vecs[i].data, 1'b0);
            watch_frame(1'b0, 4, vecs[i].frame, vecs[i].rdata, 16, 169, $sformatf("vec%0d", i));
            @(posedge clk); #1;
            check($sformatf("vec%0d idle after done", i), 32'({done_a, ready_a, busy_a, load_a}), 32'b0100);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("vec%0d rdata hold", i), 32'(rdata_a), 32'(vecs[i].rdata));
        end

        // Back-to-back with cmd_valid_i held; inputs change while busy and must be ignored.
        dout_pat = 19'h0F0F0;
        do_accept(1'b0, 7'h11, 12'h222, 1'b1);
        addr_a = 7'h33; data_a = 12'h444;
        watch_frame(1'b0, 4, 19'h11222, 19'h0F0F0, 16, 169, "b2b first");
        @(posedge clk); #1;
        check("b2b idle gap", 32'({ready_a, busy_a, load_a, done_a}), 32'b1000);
        dout_base = rise_a;
        dout_pat  = 19'h3C3C3;
        @(posedge clk); #1;
        check("b2b second accept", 32'({busy_a, ready_a}), 32'b10);
        valid_a = 1'b0;
        watch_frame(1'b0, 4, 19'h33444, 19'h3C3C3, 16, 169, "b2b second");

        // Reset in the middle of SHIFT.
        dout_pat = 19'h12345;
        do_accept(1'b0, 7'h7F, 12'hFFF, 1'b0);
        for (int n = 0; n < 200; n++) begin
            if (rise_a - dout_base >= 9) break;
            @(posedge clk); #1;
        end
        check("midrst reached bit 9", rise_a - dout_base, 9);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst outputs", 32'({ready_a, busy_a, done_a, rdata_a, sclk_a, din_a, load_a}), 32'd0);
        begin
            int ld_seen;
            ld_seen = 0;
            repeat (3) begin
                @(posedge clk); #1;
                if (load_a !== 1'b0) ld_seen++;
            end
            rst = 1'b0;
            for (int n = 0; n < 20; n++) begin
                @(posedge clk); #1;
                if (load_a !== 1'b0) ld_seen++;
            end
            check("midrst no load pulse", ld_seen, 0);
        end
        check("midrst ready after release", 32'(ready_a), 32'd1);
        dout_pat = vecs[0].dpat;
        do_accept(1'b0, vecs[0].addr, vecs[0].data, 1'b0);
        watch_frame(1'b0, 4, vecs[0].frame, vecs[0].rdata, 16, 169, "after midrst");

        // CLK_DIV=1, LOAD_HOLD=1 instance.
        do_accept(1'b1, 7'h2A, 12'hABC, 1'b0);
        watch_frame(1'b1, 1, 19'h2AABC, 19'h00000, 2, 41, "div1");
        @(posedge clk); #1;
        check("div1 idle after done", 32'({done_b, ready_b, busy_b}), 32'b010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1);
    end

endmodule

`default_nettype wire
